// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC generation, instruction SRAM request and a
// one-entry instruction buffer that holds the fetched word across decode stalls.
module if_stage #(
    parameter logic [31:0] RESET_PC        = 32'hbfc00000,
    parameter int unsigned BR_BUS_WD       = 33,
    parameter int unsigned FS_TO_DS_BUS_WD = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_en,
    output logic [3:0]                 inst_sram_wen,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic [31:0]                inst_sram_rdata
);

    logic        to_fs_valid_q;
    logic        fs_valid_q,       fs_valid_d;
    logic [31:0] fs_pc_q,          fs_pc_d;
    logic        br_pending_q,     br_pending_d;
    logic [31:0] br_pend_target_q, br_pend_target_d;
    logic        inst_buf_valid_q, inst_buf_valid_d;
    logic [31:0] inst_buf_q,       inst_buf_d;

    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_allowin;
    logic        issue;
    logic        pend_set;
    logic [31:0] nextpc;
    logic [31:0] fs_inst;

    assign br_taken   = br_bus[32];
    assign br_target  = br_bus[31:0];
    assign fs_allowin = !fs_valid_q || ds_allowin;
    assign issue      = to_fs_valid_q && fs_allowin;
    // A branch seen before its delay slot was fetched: fetch the slot now, target next.
    assign pend_set   = issue && br_taken && !fs_valid_q && !br_pending_q;

    always_comb begin
        if (br_pending_q) begin
            nextpc = br_pend_target_q;
        end else if (br_taken && fs_valid_q) begin
            nextpc = br_target;
        end else begin
            nextpc = 32'(fs_pc_q + 32'd4);
        end
    end

    always_comb begin
        fs_valid_d       = fs_valid_q;
        fs_pc_d          = fs_pc_q;
        br_pending_d     = br_pending_q;
        br_pend_target_d = br_pend_target_q;
        inst_buf_valid_d = inst_buf_valid_q;
        inst_buf_d       = inst_buf_q;

        if (issue) begin
            fs_valid_d   = 1'b1;
            fs_pc_d      = nextpc;
            br_pending_d = pend_set;
        end else if (fs_allowin) begin
            fs_valid_d = 1'b0;
        end

        if (pend_set) begin
            br_pend_target_d = br_target;
        end

        // SRAM data is only valid for one cycle, so park it while decode stalls.
        if (fs_valid_q && ds_allowin) begin
            inst_buf_valid_d = 1'b0;
        end else if (fs_valid_q && !inst_buf_valid_q) begin
            inst_buf_valid_d = 1'b1;
            inst_buf_d       = inst_sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_fs_valid_q    <= 1'b0;
            fs_valid_q       <= 1'b0;
            fs_pc_q          <= 32'(RESET_PC - 32'd4);
            br_pending_q     <= 1'b0;
            br_pend_target_q <= 32'd0;
            inst_buf_valid_q <= 1'b0;
            inst_buf_q       <= 32'd0;
        end else begin
            to_fs_valid_q    <= 1'b1;
            fs_valid_q       <= fs_valid_d;
            fs_pc_q          <= fs_pc_d;
            br_pending_q     <= br_pending_d;
            br_pend_target_q <= br_pend_target_d;
            inst_buf_valid_q <= inst_buf_valid_d;
            inst_buf_q       <= inst_buf_d;
        end
    end

    assign fs_inst         = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
    assign fs_to_ds_valid  = fs_valid_q;
    assign fs_to_ds_bus    = {fs_pc_q, fs_inst};
    assign inst_sram_en    = issue;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'd0;

endmodule
